// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// pc[IDX_BITS+1:2]. The IF stage reads a prediction combinationally. The EX
// stage trains the table with the resolved outcome. On a misprediction it
// raises a registered one-cycle flush and a redirect PC.
// Optional build macro BP_PERF_CNT_EN adds saturating resolve/mispredict
// counters. Without it, perf_branches and perf_mispredicts read as zero.
module branch_predictor #(
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        ex_br_en,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          bht [ENTRIES];
    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [1:0]          cur_ctr;
    logic [1:0]          next_ctr;
    logic                resolve;
    logic                mispredict;
    logic                unused_if_pc_bits;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];

    // Only the index bits of the fetch PC matter; fold away the rest.
    assign unused_if_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

    // Prediction is the counter's MSB. The read sees pre-update table state.
    assign pred_taken = bht[if_idx][1];

    // A branch in EX during a flush cycle is wrong-path. A stalled branch waits
    // until it leaves stall, so it is resolved exactly once.
    assign resolve    = ex_valid & ex_is_branch & ~ex_stall & ~flush;
    assign mispredict = resolve & (ex_br_en != ex_pred_taken);
    assign cur_ctr    = bht[ex_idx];

    // Saturating increment on taken and saturating decrement on not-taken.
    always_comb begin
        next_ctr = cur_ctr;
        if (ex_br_en) begin
            if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'b01;
        end else begin
            if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'b01;
        end
    end

    // On reset, load every entry weakly not-taken. Afterwards, train on resolve.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[IDX_BITS'(i)] <= INIT_CTR;
            end
        end else if (resolve) begin
            bht[ex_idx] <= next_ctr;
        end
    end

    // Flush is a one-cycle pulse. Redirect holds its value until the next mispredict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush       <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= ex_br_en ? ex_target : ex_pc + 32'd4;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    // Event counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt     <= 32'd0;
            mispredict_cnt <= 32'd0;
        end else begin
            if (resolve && branch_cnt != 32'hFFFF_FFFF) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict && mispredict_cnt != 32'hFFFF_FFFF) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

    assign perf_branches    = branch_cnt;
    assign perf_mispredicts = mispredict_cnt;
`else
    assign perf_branches    = 32'd0;
    assign perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. A reference model predicts the
// next-cycle flush, redirect and perf outputs whenever stimulus is driven. The
// predictions go into a scoreboard queue. They are popped and compared after
// the clock edge. Directed spot checks use constants derived by hand.
module tb_branch_predictor;

    localparam int         IDX_BITS = 6;
    localparam logic [1:0] INIT_CTR = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        ex_br_en;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    typedef struct {
        string       tag;
        logic        flush;
        logic [31:0] redirect_pc;
        logic [31:0] perf_b;
        logic [31:0] perf_m;
    } exp_t;

    exp_t        sb_q[$];
    logic [1:0]  m_bht [64];
    logic        m_flush;
    logic [31:0] m_redirect;
    logic [31:0] m_pb;
    logic [31:0] m_pm;
    int          pass_count  = 0;
    int          check_count = 0;

    branch_predictor #(.IDX_BITS(IDX_BITS), .INIT_CTR(INIT_CTR)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_br_en         (ex_br_en),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    function automatic logic model_pred(input logic [31:0] pc);
        return m_bht[pc[7:2]][1];
    endfunction

    function automatic logic perf_on();
`ifdef BP_PERF_CNT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle of inputs. Check the combinational prediction, push the
    // model's expectation, then pop and compare after the edge.
    task automatic apply_stimulus(input string tag, input logic rst, input logic vld,
                                  input logic stl, input logic br, input logic [31:0] epc,
                                  input logic [31:0] tgt, input logic ep, input logic ben,
                                  input logic [31:0] ipc);
        exp_t        e;
        logic        res;
        logic        mis;
        logic [5:0]  idx;
        @(negedge clk);
        rst_n = rst; ex_valid = vld; ex_stall = stl; ex_is_branch = br;
        ex_pc = epc; ex_target = tgt; ex_pred_taken = ep; ex_br_en = ben; if_pc = ipc;
        #1;
        check_output({tag, "/pred"}, {31'd0, pred_taken}, {31'd0, model_pred(ipc)});
        idx = epc[7:2];
        res = vld && br && !stl && !m_flush;
        mis = res && (ben != ep);
        if (!rst) begin
            for (int i = 0; i < 64; i++) m_bht[i] = INIT_CTR;
            m_flush = 1'b0; m_redirect = 32'd0; m_pb = 32'd0; m_pm = 32'd0;
        end else begin
            if (res) begin
                if (ben && m_bht[idx] != 2'd3) m_bht[idx] = m_bht[idx] + 2'd1;
                else if (!ben && m_bht[idx] != 2'd0) m_bht[idx] = m_bht[idx] - 2'd1;
                if (perf_on()) m_pb = m_pb + 32'd1;
            end
            m_flush = mis;
            if (mis) begin
                m_redirect = ben ? tgt : epc + 32'd4;
                if (perf_on()) m_pm = m_pm + 32'd1;
            end
        end
        e.tag = tag; e.flush = m_flush; e.redirect_pc = m_redirect;
        e.perf_b = m_pb; e.perf_m = m_pm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_output({e.tag, "/flush"}, {31'd0, flush}, {31'd0, e.flush});
        check_output({e.tag, "/redirect"}, redirect_pc, e.redirect_pc);
        check_output({e.tag, "/perf_b"}, perf_branches, e.perf_b);
        check_output({e.tag, "/perf_m"}, perf_mispredicts, e.perf_m);
    endtask

    task automatic idle(input logic [31:0] ipc);
        apply_stimulus("idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ipc);
    endtask

    // Directed sequence, then a short random burst, then a reset during a resolve.
    initial begin
        rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0; ex_is_branch = 1'b0;
        ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_br_en = 1'b0;
        for (int i = 0; i < 64; i++) m_bht[i] = INIT_CTR;
        m_flush = 1'b0; m_redirect = '0; m_pb = '0; m_pm = '0;
        repeat (2) @(posedge clk);

        apply_stimulus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
        idle(32'h0);
        check_output("rst_pred_0x0", {31'd0, pred_taken}, 32'd0);
        idle(32'h4);
        check_output("rst_pred_0x4", {31'd0, pred_taken}, 32'd0);
        idle(32'hFC);
        check_output("rst_pred_0xFC", {31'd0, pred_taken}, 32'd0);
        check_output("rst_flush", {31'd0, flush}, 32'd0);

        // Counter at index 24 trains 01 -> 10 -> 11 -> 11.
        apply_stimulus("r1", 1'b1, 1'b1, 1'b0, 1'b1, 32'h60, 32'h80, model_pred(32'h60), 1'b1, 32'h60);
        check_output("r1_flush", {31'd0, flush}, 32'd1);
        check_output("r1_redirect", redirect_pc, 32'h80);
        check_output("r1_pred_after", {31'd0, pred_taken}, 32'd1);
        idle(32'h60);
        check_output("r1_flush_one_cycle", {31'd0, flush}, 32'd0);
        apply_stimulus("r2", 1'b1, 1'b1, 1'b0, 1'b1, 32'h60, 32'h80, model_pred(32'h60), 1'b1, 32'h60);
        apply_stimulus("r3", 1'b1, 1'b1, 1'b0, 1'b1, 32'h60, 32'h80, model_pred(32'h60), 1'b1, 32'h60);
        apply_stimulus("r4", 1'b1, 1'b1, 1'b0, 1'b1, 32'h60, 32'h80, model_pred(32'h60), 1'b1, 32'h60);
        check_output("r4_no_flush", {31'd0, flush}, 32'd0);
        check_output("r4_redirect_held", redirect_pc, 32'h80);
        // Saturated at 11, so one not-taken resolve still predicts taken.
        apply_stimulus("r5", 1'b1, 1'b1, 1'b0, 1'b1, 32'h60, 32'h80, 1'b1, 1'b0, 32'h60);
        check_output("r5_pred_still_taken", {31'd0, pred_taken}, 32'd1);
        check_output("r5_redirect", redirect_pc, 32'h64);
        idle(32'h60);

        // PC+4 wraps around to zero.
        apply_stimulus("wrap", 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b0, 32'h0);
        check_output("wrap_flush", {31'd0, flush}, 32'd1);
        check_output("wrap_redirect", redirect_pc, 32'h0);
        idle(32'h0);
        check_output("wrap_flush_one_cycle", {31'd0, flush}, 32'd0);

        // A branch in EX during the flush cycle is ignored.
        apply_stimulus("mis_n", 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 32'h104);
        apply_stimulus("wrongpath", 1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h300, 1'b0, 1'b1, 32'h104);
        check_output("wrongpath_no_flush", {31'd0, flush}, 32'd0);
        check_output("wrongpath_redirect", redirect_pc, 32'h200);
        idle(32'h104);
        check_output("wrongpath_no_train", {31'd0, pred_taken}, 32'd0);

        // A stalled mispredicted branch resolves once when the stall drops.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("stall", 1'b1, 1'b1, 1'b1, 1'b1, 32'h108, 32'h400, 1'b0, 1'b1, 32'h108);
            check_output("stall_no_flush", {31'd0, flush}, 32'd0);
        end
        apply_stimulus("unstall", 1'b1, 1'b1, 1'b0, 1'b1, 32'h108, 32'h400, 1'b0, 1'b1, 32'h108);
        check_output("unstall_flush", {31'd0, flush}, 32'd1);
        check_output("unstall_redirect", redirect_pc, 32'h400);
        idle(32'h108);
        check_output("unstall_single_flush", {31'd0, flush}, 32'd0);
        check_output("unstall_trained", {31'd0, pred_taken}, 32'd1);

        // Same-cycle read and write at index 16 returns the old value.
        apply_stimulus("collide", 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h500, 1'b0, 1'b1, 32'h40);
        check_output("collide_next_pred", {31'd0, pred_taken}, 32'd1);
        idle(32'h40);
        check_output("perf_branches_total", perf_branches, perf_on() ? 32'd9 : 32'd0);
        check_output("perf_mispredicts_total", perf_mispredicts, perf_on() ? 32'd6 : 32'd0);

        // Random mix of stimulus checked against the model.
        for (int i = 0; i < 40; i++) begin
            apply_stimulus("rand", 1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 3) != 0), {24'd0, 2'($urandom_range(0, 3)), 6'd0},
                           $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           {24'd0, 2'($urandom_range(0, 3)), 6'd0});
        end

        // Reset wins over a mispredicted resolve in the same cycle.
        apply_stimulus("rst_over", 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h600, 1'b0, 1'b1, 32'h40);
        check_output("rst_over_flush", {31'd0, flush}, 32'd0);
        check_output("rst_over_pred", {31'd0, pred_taken}, 32'd0);
        idle(32'h40);

        if (sb_q.size() != 0) check_output("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch history table (BHT) of 2-bit saturating counters.
- Sits directly downstream of the EX-stage branch comparator and consumes its br_en result.
- IF side: gives a taken/not-taken prediction for the fetch PC.
- EX side: trains the table with the resolved br_en, detects mispredictions and issues a registered one-cycle flush/redirect to the fetch unit.

Parameters:
- IDX_BITS, 6, log2 of BHT entries; index = pc[IDX_BITS+1:2].
- INIT_CTR, 2'b01, counter value loaded into every entry on reset (weakly not-taken).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- if_pc  input  32  fetch-stage PC.
- pred_taken  output  1  combinational: counter[if_pc index] bit 1.
- ex_valid  input  1  EX stage holds a live instruction.
- ex_stall  input  1  pipeline stalled; EX inputs are held and must not be re-consumed.
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_pc  input  32  PC of the EX instruction.
- ex_target  input  32  computed branch target (pc + B-imm).
- ex_pred_taken  input  1  prediction carried down the pipe with this instruction.
- ex_br_en  input  1  resolved outcome from the comparator.
- flush  output  1  one-cycle pulse: kill IF/ID/EX younger instructions.
- redirect_pc  output  32  fetch PC to load while flush=1.
- perf_branches  output  32  resolved-branch count (see Optional Feature).
- perf_mispredicts  output  32  misprediction count (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at an edge): every BHT entry <= INIT_CTR; flush=0; redirect_pc=0; perf counters=0. Reset overrides a resolve in the same cycle. Any pending flush is dropped.
- Resolve event: ex_valid & ex_is_branch & !ex_stall & !flush.
  - Gating on !flush: the instruction in EX while flush=1 is wrong-path and is ignored.
  - Gating on !ex_stall: a stalled branch is resolved exactly once, on the cycle it leaves stall.
- Counter update on a resolve event, at the index of ex_pc:
  - ex_br_en=1: ctr <= (ctr==3) ? 3 : ctr+1.
  - ex_br_en=0: ctr <= (ctr==0) ? 0 : ctr-1.
  - Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Misprediction: a resolve event with ex_br_en != ex_pred_taken.
  - Next cycle: flush=1 for exactly one cycle.
  - redirect_pc = ex_br_en ? ex_target : ex_pc + 32'd4. Modulo-2^32 add: 0xFFFFFFFC wraps to 0x00000000.
  - Correct prediction: flush=0; redirect_pc holds its last value.
- Latency:
  - Prediction: 0 cycles (combinational read of table state).
  - Redirect: 1 cycle after the resolve edge.
- Read/write collision: when if_pc and ex_pc map to the same index in the same cycle, pred_taken reflects the pre-update value (read-before-write). The new value is visible next cycle.
- Aliasing: distinct PCs with equal index share an entry; no tag check.
- Non-branch or invalid EX instruction: no table change, no flush.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined:
  - perf_branches += 1 on every resolve event.
  - perf_mispredicts += 1 on every misprediction.
  - Both saturate at 32'hFFFFFFFF and do not wrap.
  - Both reset to 0.
- Undefined: no counter flops are built; perf_branches and perf_mispredicts are tied to 0.

Test Plan:
- Reset -> pred_taken=0 for if_pc 0x0, 0x4 and 0xFC; flush=0; perf=0.
- Four consecutive resolves, ex_pc=0x60 (index 24), ex_br_en=1, ex_pred_taken matching current prediction -> counter 01→10→11→11. flush pulses only on the first resolve, with redirect_pc=ex_target=0x80. pred_taken for if_pc=0x60 reads 1 after the first update.
- Mispredicted not-taken, ex_pc=0xFFFFFFFC, ex_pred_taken=1, ex_br_en=0 -> flush=1 the next cycle only; redirect_pc=0x00000000.
- Mispredict at cycle N, with another valid branch in EX at cycle N+1 (flush=1) -> second branch ignored: no counter change, no second flush, perf_branches incremented once.
- ex_stall=1 for 3 cycles with a mispredicted branch held in EX -> no flush while stalled. Exactly one flush and one counter update after stall drops.
- Same-cycle if_pc=ex_pc=0x40, counter 01, ex_br_en=1 -> pred_taken=0 that cycle and 1 the next. With BP_PERF_CNT_EN: perf_branches=1, perf_mispredicts=1 after mispredict.
